// File: rtl/muldiv_sequencer_if.sv
// Request/steering/status bundle between control_unit, the mult/div pair and
// muldiv_sequencer.
interface muldiv_sequencer_if;
   logic req_valid;
   logic req_op;
   logic flush;
   logic mult_stop;
   logic div_stop;
   logic div_zero;
   logic busy;
   logic mult_init;
   logic div_init;
   logic mux_high;
   logic mux_low;
   logic high_load;
   logic low_load;
   logic done;
   logic div_zero_exc;
   logic timeout_exc;

   modport master (
      output req_valid, req_op, flush, mult_stop, div_stop, div_zero,
      input  busy, mult_init, div_init, mux_high, mux_low, high_load, low_load,
             done, div_zero_exc, timeout_exc
   );

   modport slave (
      input  req_valid, req_op, flush, mult_stop, div_stop, div_zero,
      output busy, mult_init, div_init, mux_high, mux_low, high_load, low_load,
             done, div_zero_exc, timeout_exc
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT or DIV on the shared multiplier/divider. It then loads
// HI/LO, or reports divide-by-zero or timeout. All outputs decode from state.
module muldiv_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 40,
   parameter int unsigned CNT_W          = 6
) (
   input logic               clk,
   input logic               reset_in,
   muldiv_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWait,
      StWrite,
      StExcDz,
      StExcTo
   } state_e;

   state_e           state_q, state_d;
   logic             op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             unit_stop;

   assign unit_stop = op_q ? bus.div_stop : bus.mult_stop;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               op_d    = bus.req_op;
               state_d = StStart;
            end
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            cnt_d = cnt_q + 1'b1;
            if (op_q && bus.div_zero) begin
               state_d = StExcDz;
            end else if (unit_stop) begin
               state_d = StWrite;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_d = StExcTo;
            end
         end
         StWrite, StExcDz, StExcTo: state_d = StIdle;
         default:                   state_d = StIdle;
      endcase
      // Abort beats every other transition; op_q is kept for the muxes.
      if (bus.flush) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or posedge reset_in) begin
      if (reset_in) begin
         state_q <= StIdle;
         op_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      bus.busy         = (state_q != StIdle);
      bus.mult_init    = (state_q == StStart) && !op_q;
      bus.div_init     = (state_q == StStart) && op_q;
      bus.mux_high     = op_q;
      bus.mux_low      = op_q;
      bus.high_load    = (state_q == StWrite);
      bus.low_load     = (state_q == StWrite);
      bus.done         = (state_q == StWrite);
      bus.div_zero_exc = (state_q == StExcDz);
      bus.timeout_exc  = (state_q == StExcTo);
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer; output vector bit order is
// {busy, mult_init, div_init, mux_high, mux_low, high_load, low_load, done, dz_exc, to_exc}.
module tb_muldiv_sequencer;

   localparam logic [9:0] OIdle    = 10'h000;
   localparam logic [9:0] OIdleDiv = 10'h060;
   localparam logic [9:0] OStartM  = 10'h300;
   localparam logic [9:0] OStartD  = 10'h2E0;
   localparam logic [9:0] OWaitM   = 10'h200;
   localparam logic [9:0] OWaitD   = 10'h260;
   localparam logic [9:0] OWriteM  = 10'h21C;
   localparam logic [9:0] OWriteD  = 10'h27C;
   localparam logic [9:0] ODzExc   = 10'h262;
   localparam logic [9:0] OToExcM  = 10'h201;

   logic       clk = 1'b0;
   logic       reset_in;
   logic [9:0] outs;
   int         n_checks = 0;
   int         n_fail   = 0;

   muldiv_sequencer_if bus ();

   muldiv_sequencer #(
      .TIMEOUT_CYCLES(40),
      .CNT_W         (6)
   ) dut (
      .clk     (clk),
      .reset_in(reset_in),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   assign outs = {bus.busy, bus.mult_init, bus.div_init, bus.mux_high, bus.mux_low,
                  bus.high_load, bus.low_load, bus.done, bus.div_zero_exc, bus.timeout_exc};

   task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic op);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      tick();
      bus.req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_in      = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 1'b0;
      bus.flush     = 1'b0;
      bus.mult_stop = 1'b0;
      bus.div_stop  = 1'b0;
      bus.div_zero  = 1'b0;
      tick();
      tick();
      reset_in = 1'b0;
      check_val("reset_idle", outs, OIdle);

      // MULT, stop in the 32nd WAIT cycle
      request(1'b0);
      check_val("mult_start", outs, OStartM);
      tick();
      for (int i = 0; i < 32; i++) begin
         check_val("mult_wait", outs, OWaitM);
         if (i == 31) bus.mult_stop = 1'b1;
         tick();
      end
      bus.mult_stop = 1'b0;
      check_val("mult_write", outs, OWriteM);
      tick();
      check_val("mult_idle", outs, OIdle);

      // DIV with div_zero and div_stop together in the 5th WAIT cycle
      request(1'b1);
      check_val("dz_start", outs, OStartD);
      tick();
      for (int i = 0; i < 5; i++) begin
         check_val("dz_wait", outs, OWaitD);
         if (i == 4) begin
            bus.div_zero = 1'b1;
            bus.div_stop = 1'b1;
         end
         tick();
      end
      bus.div_zero = 1'b0;
      bus.div_stop = 1'b0;
      check_val("dz_exc", outs, ODzExc);
      tick();
      check_val("dz_idle", outs, OIdleDiv);

      // DIV ignores mult_stop and a new MULT request while busy
      request(1'b1);
      tick();
      bus.mult_stop = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("iso_wait", outs, OWaitD);
      end
      bus.mult_stop = 1'b0;
      bus.req_valid = 1'b0;
      bus.div_stop  = 1'b1;
      tick();
      bus.div_stop = 1'b0;
      check_val("iso_write", outs, OWriteD);
      tick();
      check_val("iso_idle", outs, OIdleDiv);

      // Timeout; div_zero/div_stop noise must be ignored during MULT
      request(1'b0);
      check_val("to_start", outs, OStartM);
      bus.div_zero = 1'b1;
      bus.div_stop = 1'b1;
      tick();
      for (int c = 2; c <= 41; c++) begin
         check_val("to_wait", outs, OWaitM);
         tick();
      end
      bus.div_zero = 1'b0;
      bus.div_stop = 1'b0;
      check_val("to_exc", outs, OToExcM);
      tick();
      check_val("to_idle", outs, OIdle);

      // Stop on the last WAIT cycle wins over timeout
      request(1'b0);
      tick();
      for (int c = 2; c <= 41; c++) begin
         if (c == 41) bus.mult_stop = 1'b1;
         tick();
      end
      bus.mult_stop = 1'b0;
      check_val("race_write", outs, OWriteM);

      // Request held through the IDLE cycle after WRITE starts a new DIV
      bus.req_valid = 1'b1;
      bus.req_op    = 1'b1;
      tick();
      check_val("b2b_idle", outs, OIdle);
      tick();
      bus.req_valid = 1'b0;
      check_val("b2b_start", outs, OStartD);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_val("b2b_flush_idle", outs, OIdleDiv);

      // Flush mid-WAIT, then a MULT accepted at the following edge
      request(1'b0);
      tick();
      tick();
      bus.flush = 1'b1;
      #1;
      check_val("flush_cycle", outs, OWaitM);
      tick();
      bus.flush = 1'b0;
      check_val("flush_idle", outs, OIdle);
      request(1'b0);
      check_val("flush_restart", outs, OStartM);
      tick();
      bus.mult_stop = 1'b1;
      tick();
      bus.mult_stop = 1'b0;
      check_val("flush_write", outs, OWriteM);
      tick();

      // Asynchronous reset mid-WAIT of a DIV
      request(1'b1);
      tick();
      check_val("rst_pre", outs, OWaitD);
      #2;
      reset_in = 1'b1;
      #1;
      check_val("rst_async", outs, OIdle);
      tick();
      reset_in = 1'b0;
      tick();
      check_val("rst_after", outs, OIdle);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
